// File: rtl/pifo_pop_collector_pkg.sv
// Shared widths, entry layout and the empty-tree sentinel for the PIFO pop collector.
// Defaults here mirror the top-level parameter defaults.
package pifo_pop_collector_pkg;

   localparam int PTW_DEF        = 16;
   localparam int MTW_DEF        = 0;
   localparam int PLW_DEF        = 8;
   localparam int LEVEL_DEF      = 4;
   localparam int TREE_NUM_DEF   = 4;
   localparam int LANE_DEPTH_DEF = 4;
   localparam int CNT_W_DEF      = 16;

   function automatic int calc_dw(input int mtw, input int ptw, input int plw);
      return mtw + ptw + plw;
   endfunction

   function automatic int calc_tnb(input int tree_num);
      return (tree_num <= 1) ? 1 : $clog2(tree_num);
   endfunction

   localparam int DW_DEF  = calc_dw(MTW_DEF, PTW_DEF, PLW_DEF);
   localparam int TNB_DEF = calc_tnb(TREE_NUM_DEF);

   typedef struct packed {
      logic [TNB_DEF-1:0] tree_id;
      logic [DW_DEF-1:0]  data;
   } pop_entry_t;

   // Wide all-ones constant; users slice it down to their own data width.
   localparam logic [255:0] POP_EMPTY = '1;

endpackage

// File: rtl/pifo_pop_collector_lane_fifo.sv
// Small per-lane FIFO with show-ahead read data; a write while full is accepted
// when the same cycle also reads.
module pifo_pop_collector_lane_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          arst,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_wr;
   logic          do_rd;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rd_data = mem[rd_ptr_reg];
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);

   // Storage needs no reset: occupancy is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_rd) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + CW'(do_wr) - CW'(do_rd);
      end
   end

endmodule

// File: rtl/pifo_pop_collector.sv
// Collects per-lane PIFO pop results, drops empty-tree sentinels, buffers each lane
// and round-robin merges them onto one registered valid/ready egress stream.
module pifo_pop_collector
   import pifo_pop_collector_pkg::*;
#(
   parameter int PTW        = PTW_DEF,
   parameter int MTW        = MTW_DEF,
   parameter int PLW        = PLW_DEF,
   parameter int LEVEL      = LEVEL_DEF,
   parameter int TREE_NUM   = TREE_NUM_DEF,
   parameter int LANE_DEPTH = LANE_DEPTH_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   localparam int DW        = calc_dw(MTW, PTW, PLW),
   localparam int TNB       = calc_tnb(TREE_NUM),
   localparam int LW        = $clog2(LEVEL)
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic [LEVEL-1:0]     i_is_level0_pop,
   input  logic [LEVEL*DW-1:0]  i_pop_data,
   input  logic [LEVEL*TNB-1:0] i_tree_id,
   output logic [LEVEL-1:0]     o_lane_room,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [DW-1:0]        o_data,
   output logic [TNB-1:0]       o_tree_id,
   output logic [LW-1:0]        o_lane,
   output logic [LEVEL-1:0]     o_overflow,
   output logic [CNT_W-1:0]     o_empty_cnt
);

   localparam int EW = TNB + DW;
   localparam int CW = $clog2(LANE_DEPTH) + 1;
   localparam logic [DW-1:0] SENTINEL = POP_EMPTY[DW-1:0];

   logic [LEVEL-1:0] sentinel;
   logic [LEVEL-1:0] sent_hits;
   logic [LEVEL-1:0] wr_en;
   logic [LEVEL-1:0] rd_en;
   logic [LEVEL-1:0] full;
   logic [LEVEL-1:0] empty;
   logic [LEVEL-1:0] drop;
   logic [EW-1:0]    wr_entry [LEVEL];
   logic [EW-1:0]    rd_entry [LEVEL];
   logic [CW-1:0]    count    [LEVEL];

   logic [LW-1:0]    ptr_reg;
   logic             valid_reg;
   logic [DW-1:0]    data_reg;
   logic [TNB-1:0]   tree_reg;
   logic [LW-1:0]    lane_reg;
   logic [LEVEL-1:0] overflow_reg;
   logic [CNT_W-1:0] empty_cnt_reg;
   logic [CNT_W-1:0] empty_cnt_next;
   logic [CNT_W:0]   cnt_sum;

   logic [LW-1:0]    grant;
   logic             grant_found;
   logic             load_en;

   assign load_en = ~valid_reg | i_ready;

   generate
      for (genvar gi = 0; gi < LEVEL; gi++) begin : g_lane
         assign sentinel[gi]    = (i_pop_data[gi*DW +: DW] == SENTINEL);
         assign wr_entry[gi]    = {i_tree_id[gi*TNB +: TNB], i_pop_data[gi*DW +: DW]};
         assign rd_en[gi]       = load_en & grant_found & (grant == LW'(gi));
         assign wr_en[gi]       = i_is_level0_pop[gi] & ~sentinel[gi] & (~full[gi] | rd_en[gi]);
         assign drop[gi]        = i_is_level0_pop[gi] & ~sentinel[gi] & full[gi] & ~rd_en[gi];
         assign sent_hits[gi]   = i_is_level0_pop[gi] & sentinel[gi];
         assign o_lane_room[gi] = (count[gi] <= CW'(LANE_DEPTH - 2));

         pifo_pop_collector_lane_fifo #(
            .W     (EW),
            .DEPTH (LANE_DEPTH)
         ) u_fifo (
            .clk     (i_clk),
            .arst    (i_arst),
            .wr_en   (wr_en[gi]),
            .wr_data (wr_entry[gi]),
            .rd_en   (rd_en[gi]),
            .rd_data (rd_entry[gi]),
            .full    (full[gi]),
            .empty   (empty[gi]),
            .count   (count[gi])
         );
      end
   endgenerate

   // Scan from the far end back toward ptr so the lane closest to ptr wins.
   always_comb begin
      grant       = ptr_reg;
      grant_found = 1'b0;
      for (int k = LEVEL - 1; k >= 0; k--) begin
         if (!empty[ptr_reg + LW'(k)]) begin
            grant       = ptr_reg + LW'(k);
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_sum = {1'b0, empty_cnt_reg};
      for (int k = 0; k < LEVEL; k++) begin
         cnt_sum = cnt_sum + {{CNT_W{1'b0}}, sent_hits[k]};
      end
   end

   assign empty_cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         ptr_reg       <= '0;
         valid_reg     <= 1'b0;
         data_reg      <= '0;
         tree_reg      <= '0;
         lane_reg      <= '0;
         overflow_reg  <= '0;
         empty_cnt_reg <= '0;
      end else begin
         overflow_reg  <= overflow_reg | drop;
         empty_cnt_reg <= empty_cnt_next;
         if (load_en) begin
            valid_reg <= grant_found;
            if (grant_found) begin
               data_reg <= rd_entry[grant][DW-1:0];
               tree_reg <= rd_entry[grant][EW-1:DW];
               lane_reg <= grant;
               ptr_reg  <= grant + LW'(1);
            end
         end
      end
   end

   assign o_valid     = valid_reg;
   assign o_data      = data_reg;
   assign o_tree_id   = tree_reg;
   assign o_lane      = lane_reg;
   assign o_overflow  = overflow_reg;
   assign o_empty_cnt = empty_cnt_reg;

endmodule

// File: tb/tb_pifo_pop_collector.sv
// Randomised and directed bench for pifo_pop_collector with a queue-based reference
// model and an egress scoreboard checked at every accepted handshake.
module tb_pifo_pop_collector;
   import pifo_pop_collector_pkg::*;

   localparam int LEVEL = LEVEL_DEF;
   localparam int DW    = DW_DEF;
   localparam int TNB   = TNB_DEF;
   localparam int LW    = $clog2(LEVEL);
   localparam int DEPTH = LANE_DEPTH_DEF;
   localparam int CNT_W = CNT_W_DEF;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic                 i_clk = 1'b0;
   logic                 i_arst = 1'b1;
   logic [LEVEL-1:0]     i_is_level0_pop = '0;
   logic [LEVEL*DW-1:0]  i_pop_data = '0;
   logic [LEVEL*TNB-1:0] i_tree_id = '0;
   logic [LEVEL-1:0]     o_lane_room;
   logic                 o_valid;
   logic                 i_ready = 1'b0;
   logic [DW-1:0]        o_data;
   logic [TNB-1:0]       o_tree_id;
   logic [LW-1:0]        o_lane;
   logic [LEVEL-1:0]     o_overflow;
   logic [CNT_W-1:0]     o_empty_cnt;

   always #5 i_clk = ~i_clk;

   pifo_pop_collector dut (
      .i_clk           (i_clk),
      .i_arst          (i_arst),
      .i_is_level0_pop (i_is_level0_pop),
      .i_pop_data      (i_pop_data),
      .i_tree_id       (i_tree_id),
      .o_lane_room     (o_lane_room),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_data          (o_data),
      .o_tree_id       (o_tree_id),
      .o_lane          (o_lane),
      .o_overflow      (o_overflow),
      .o_empty_cnt     (o_empty_cnt)
   );

   typedef struct {
      pop_entry_t e;
      int         lane;
   } exp_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one queue per lane, an output slot and a round-robin pointer.
   pop_entry_t       lane_q [LEVEL][$];
   exp_t             exp_q[$];
   bit               m_valid = 1'b0;
   int               m_ptr = 0;
   logic [LEVEL-1:0] m_ovf = '0;
   int               m_cnt = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      foreach (lane_q[i]) lane_q[i].delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
      m_ovf   = '0;
      m_cnt   = 0;
   endtask

   task automatic tick();
      @(negedge i_clk);
   endtask

   task automatic set_lane(input int i, input logic [DW-1:0] d, input logic [TNB-1:0] t);
      i_pop_data[i*DW +: DW]   = d;
      i_tree_id[i*TNB +: TNB]  = t;
   endtask

   task automatic do_reset();
      tick();
      i_arst          = 1'b1;
      i_is_level0_pop = '0;
      i_ready         = 1'b0;
      model_clear();
      tick();
      i_arst = 1'b0;
   endtask

   // Model advances on each rising edge using the inputs driven at the previous falling edge.
   initial begin : model
      bit         ld;
      int         g;
      int         idx;
      int         hits;
      pop_entry_t e;
      pop_entry_t n;
      exp_t       x;
      forever begin
         @(posedge i_clk);
         if (!i_arst) begin
            ld = !m_valid || i_ready;
            g  = -1;
            if (ld) begin
               for (int k = 0; k < LEVEL; k++) begin
                  idx = (m_ptr + k) % LEVEL;
                  if (g < 0 && lane_q[idx].size() > 0) g = idx;
               end
            end
            if (g >= 0) e = lane_q[g].pop_front();
            hits = 0;
            for (int i = 0; i < LEVEL; i++) begin
               if (i_is_level0_pop[i]) begin
                  n.data    = i_pop_data[i*DW +: DW];
                  n.tree_id = i_tree_id[i*TNB +: TNB];
                  if (n.data == {DW{1'b1}}) hits++;
                  else if (lane_q[i].size() < DEPTH) lane_q[i].push_back(n);
                  else m_ovf[i] = 1'b1;
               end
            end
            m_cnt = (m_cnt + hits > CMAX) ? CMAX : m_cnt + hits;
            if (ld) begin
               if (g >= 0) begin
                  m_valid = 1'b1;
                  x.e     = e;
                  x.lane  = g;
                  exp_q.push_back(x);
                  m_ptr   = (g + 1) % LEVEL;
               end else begin
                  m_valid = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: status compared every cycle; egress entries popped from the scoreboard on handshake.
   initial begin : monitor
      exp_t             x;
      logic [LEVEL-1:0] room;
      forever begin
         @(negedge i_clk);
         #2;
         if (!i_arst) begin
            for (int i = 0; i < LEVEL; i++) room[i] = (lane_q[i].size() <= DEPTH - 2);
            chk("valid", o_valid, m_valid);
            chk("overflow", o_overflow, m_ovf);
            chk("empty_cnt", o_empty_cnt, m_cnt);
            chk("lane_room", o_lane_room, room);
            if (o_valid && i_ready) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("[TB] FAIL egress_unexpected: got lane %0d data %0h, expected none", o_lane, o_data);
               end else begin
                  x = exp_q.pop_front();
                  $display("[TB] egress lane=%0d tree=%0d data=%06h", o_lane, o_tree_id, o_data);
                  chk("egress_data", o_data, x.e.data);
                  chk("egress_tree", o_tree_id, x.e.tree_id);
                  chk("egress_lane", o_lane, x.lane);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      // Reset state while reset is held
      tick();
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_tree", o_tree_id, 0);
      chk("rst_lane", o_lane, 0);
      chk("rst_overflow", o_overflow, 0);
      chk("rst_empty_cnt", o_empty_cnt, 0);
      chk("rst_lane_room", o_lane_room, 4'hF);
      tick();
      i_arst = 1'b0;

      // 1: single pulse latency
      tick();
      i_ready = 1'b1;
      set_lane(2, 24'h000123, 2'd1);
      i_is_level0_pop = 4'b0100;
      tick();
      i_is_level0_pop = '0;
      chk("t1_valid_t1", o_valid, 0);
      tick();
      chk("t1_valid_t2", o_valid, 1);
      chk("t1_data", o_data, 24'h000123);
      chk("t1_tree", o_tree_id, 1);
      chk("t1_lane", o_lane, 2);
      tick();
      chk("t1_valid_t3", o_valid, 0);

      // 2: all lanes at once drain in lane order, pointer wraps to 0
      do_reset();
      i_ready = 1'b1;
      for (int i = 0; i < LEVEL; i++) set_lane(i, DW'(32'h10 + i), TNB'(i));
      i_is_level0_pop = 4'hF;
      tick();
      i_is_level0_pop = '0;
      for (int k = 0; k < LEVEL; k++) begin
         tick();
         chk("t2_lane_order", o_lane, k);
      end
      tick();
      chk("t2_idle", o_valid, 0);
      set_lane(0, 24'h0000A0, 2'd0);
      set_lane(3, 24'h0000A3, 2'd3);
      i_is_level0_pop = 4'b1001;
      tick();
      i_is_level0_pop = '0;
      tick();
      chk("t2_ptr_wrapped", o_lane, 0);
      tick();
      chk("t2_second", o_lane, 3);

      // 3: overflow of lane 0 under backpressure, then in-order drain
      do_reset();
      i_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         set_lane(0, DW'(k), TNB'(k % 4));
         i_is_level0_pop = 4'b0001;
         tick();
      end
      i_is_level0_pop = '0;
      chk("t3_overflow", o_overflow, 4'b0001);
      chk("t3_room0", o_lane_room[0], 0);
      chk("t3_valid_held", o_valid, 1);
      i_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         chk("t3_drain_data", o_data, k);
         tick();
      end
      chk("t3_drained", o_valid, 0);

      // 4: sentinels counted, never forwarded, saturating count
      do_reset();
      i_ready = 1'b1;
      set_lane(1, {DW{1'b1}}, 2'd0);
      set_lane(3, {DW{1'b1}}, 2'd2);
      i_is_level0_pop = 4'b1010;
      tick();
      i_is_level0_pop = '0;
      chk("t4_cnt2", o_empty_cnt, 2);
      tick();
      chk("t4_no_egress", o_valid, 0);
      for (int i = 0; i < LEVEL; i++) set_lane(i, {DW{1'b1}}, 2'd0);
      i_is_level0_pop = 4'hF;
      repeat (16383) tick();
      chk("t4_near_max", o_empty_cnt, 16'hFFFE);
      tick();
      chk("t4_saturated", o_empty_cnt, 16'hFFFF);
      i_is_level0_pop = 4'b0001;
      tick();
      i_is_level0_pop = '0;
      chk("t4_stays_max", o_empty_cnt, 16'hFFFF);

      // 5: held output under backpressure while other lanes fill
      do_reset();
      i_ready = 1'b0;
      set_lane(0, 24'h0ABCDE, 2'd2);
      i_is_level0_pop = 4'b0001;
      tick();
      i_is_level0_pop = '0;
      tick();
      for (int k = 0; k < 10; k++) begin
         for (int i = 1; i < LEVEL; i++) set_lane(i, DW'($urandom_range(0, 24'hFFFFFE)), TNB'($urandom_range(0, 3)));
         i_is_level0_pop = {LEVEL{1'b0}} | LEVEL'($urandom_range(0, 7) << 1);
         tick();
         chk("t5_hold_valid", o_valid, 1);
         chk("t5_hold_data", o_data, 24'h0ABCDE);
         chk("t5_hold_lane", o_lane, 0);
      end
      i_is_level0_pop = '0;
      i_ready = 1'b1;
      repeat (20) tick();

      // 6: asynchronous reset mid-burst clears everything at once
      do_reset();
      i_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_lane(1, DW'(32'h100 + k), 2'd1);
         set_lane(2, {DW{1'b1}}, 2'd0);
         i_is_level0_pop = (k == 0) ? 4'b0110 : 4'b0010;
         tick();
      end
      set_lane(0, 24'h000055, 2'd0);
      set_lane(3, 24'h000066, 2'd3);
      i_is_level0_pop = 4'b1001;
      tick();
      i_is_level0_pop = '0;
      chk("t6_pre_overflow", o_overflow, 4'b0010);
      chk("t6_pre_cnt", o_empty_cnt, 1);
      i_arst = 1'b1;
      #1;
      chk("t6_valid", o_valid, 0);
      chk("t6_overflow", o_overflow, 0);
      chk("t6_cnt", o_empty_cnt, 0);
      chk("t6_room", o_lane_room, 4'hF);
      chk("t6_data", o_data, 0);
      model_clear();
      tick();
      i_arst = 1'b0;

      // Random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < LEVEL; i++) begin
            if ($urandom_range(0, 15) == 0) set_lane(i, {DW{1'b1}}, TNB'($urandom_range(0, 3)));
            else set_lane(i, DW'($urandom_range(0, 24'hFFFFFE)), TNB'($urandom_range(0, 3)));
            i_is_level0_pop[i] = ($urandom_range(0, 2) == 0);
         end
         i_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      i_is_level0_pop = '0;
      i_ready = 1'b1;
      repeat (30) tick();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
